count_snapshot_fifo: RTL and testbench

//  Consumer stage placed directly downstream of the 4-bit up counter.
//  - Watches the counter value every clock and detects wrap-around (MAX->0).
//  - Keeps a wrap-epoch count.
//  - On a capture strobe, queues the snapshot {epoch, count} in a small FIFO.
//  - Presents queued snapshots on a valid/ready output for a display or log stage.

---
 rtl/count_pkg.sv | 14 +
 rtl/count_snapshot_fifo_if.sv | 26 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/count_snapshot_fifo.sv | 60 ++++++
 tb/tb_count_snapshot_fifo.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared widths, snapshot type and clog2 helper for the snapshot FIFO
package count_pkg;
  localparam int CW_DEFAULT = 4;
  localparam int EW_DEFAULT = 4;
  localparam int DEPTH_DEFAULT = 4;
  localparam int SW_DEFAULT = EW_DEFAULT + CW_DEFAULT;
  typedef logic [SW_DEFAULT-1:0] snap_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/count_snapshot_fifo_if.sv
// count_snapshot_fifo_if: counter input, capture controls and snapshot output stream
interface count_snapshot_fifo_if #(
  parameter int CW = count_pkg::CW_DEFAULT,
  parameter int EW = count_pkg::EW_DEFAULT,
  parameter int DEPTH = count_pkg::DEPTH_DEFAULT
);
  localparam int LW = count_pkg::clog2(DEPTH) + 1;
  logic [CW-1:0] count_in;
  logic capture;
  logic clear_ovf;
  logic out_ready;
  logic out_valid;
  logic [EW+CW-1:0] out_data;
  logic wrap_pulse;
  logic [LW-1:0] level;
  logic full;
  logic overflow;
  modport master (
    output count_in, capture, clear_ovf, out_ready,
    input out_valid, out_data, wrap_pulse, level, full, overflow
  );
  modport slave (
    input count_in, capture, clear_ovf, out_ready,
    output out_valid, out_data, wrap_pulse, level, full, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with first-word fall-through read and level count
module sync_fifo
  import count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic push_i, pop_i;
  always_comb begin
    pop_i = pop && !empty;
    push_i = push && (!full || pop_i);
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    level_d = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_ptr_q] <= wdata;
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
endmodule

// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: wrap detector, epoch counter and sticky overflow in front of a snapshot FIFO
module count_snapshot_fifo
  import count_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int EW = EW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic clk,
  input logic rst,
  count_snapshot_fifo_if.slave bus
);
  logic [CW-1:0] prev_count_q, prev_count_d;
  logic prev_vld_q, prev_vld_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic wrap_pulse_q, wrap_pulse_d;
  logic overflow_q, overflow_d;
  logic wrap, pop, push, drop, empty;
  always_comb begin
    wrap = prev_vld_q && (&prev_count_q) && bus.count_in == '0;
    prev_count_d = bus.count_in;
    prev_vld_d = 1'b1;
    epoch_d = epoch_q + EW'(wrap);
    wrap_pulse_d = wrap;
    pop = bus.out_valid && bus.out_ready;
    push = bus.capture && (!bus.full || pop);
    drop = bus.capture && bus.full && !pop;
    overflow_d = drop || (overflow_q && !bus.clear_ovf);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_count_q <= '0;
      prev_vld_q <= 1'b0;
      epoch_q <= '0;
      wrap_pulse_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_vld_q <= prev_vld_d;
      epoch_q <= epoch_d;
      wrap_pulse_q <= wrap_pulse_d;
      overflow_q <= overflow_d;
    end
  end
  // snapshot carries the post-wrap epoch so a capture on the wrap cycle reads {new_epoch, 0}
  sync_fifo #(.WIDTH(EW+CW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata({epoch_d, bus.count_in}),
    .rdata(bus.out_data),
    .level(bus.level),
    .full(bus.full),
    .empty(empty)
  );
  assign bus.out_valid = !empty;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// tb_count_snapshot_fifo: directed checks of wrap detect, epoch, FIFO order, full and overflow
module tb_count_snapshot_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  count_snapshot_fifo_if #(.CW(4), .EW(4), .DEPTH(4)) bus ();
  count_snapshot_fifo #(.CW(4), .EW(4), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    bus.count_in = '0;
    bus.capture = 1'b0;
    bus.clear_ovf = 1'b0;
    bus.out_ready = 1'b0;
    // 1: reset state, wrap detection and epoch increment
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_wrap", 32'(bus.wrap_pulse), 0);
    for (int i = 0; i < 16; i++) begin
      bus.count_in = 4'(i);
      tick();
      chk($sformatf("nowrap_%0d", i), 32'(bus.wrap_pulse), 0);
    end
    bus.count_in = 4'd0;
    tick();
    chk("wrap_pulse", 32'(bus.wrap_pulse), 1);
    bus.count_in = 4'd1;
    bus.capture = 1'b1;
    tick();
    chk("wrap_once", 32'(bus.wrap_pulse), 0);
    chk("epoch1_valid", 32'(bus.out_valid), 1);
    chk("epoch1_data", 32'(bus.out_data), 32'h11);
    bus.capture = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("epoch1_drain", 32'(bus.out_valid), 0);
    // 2: three captures in order, then drain
    bus.out_ready = 1'b0;
    do_reset();
    bus.capture = 1'b1;
    bus.count_in = 4'd3;
    tick();
    bus.count_in = 4'd7;
    tick();
    bus.count_in = 4'd9;
    tick();
    bus.capture = 1'b0;
    chk("t2_level", 32'(bus.level), 3);
    chk("t2_head0", 32'(bus.out_data), 32'h03);
    tick();
    chk("t2_hold", 32'(bus.out_data), 32'h03);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_head1", 32'(bus.out_data), 32'h07);
    chk("t2_level2", 32'(bus.level), 2);
    tick();
    chk("t2_head2", 32'(bus.out_data), 32'h09);
    tick();
    chk("t2_empty", 32'(bus.out_valid), 0);
    chk("t2_level0", 32'(bus.level), 0);
    // 3: fill, drop, set-wins, clear
    bus.out_ready = 1'b0;
    bus.capture = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.count_in = 4'(i);
      tick();
    end
    chk("t3_full", 32'(bus.full), 1);
    chk("t3_level4", 32'(bus.level), 4);
    chk("t3_noovf", 32'(bus.overflow), 0);
    bus.count_in = 4'd5;
    tick();
    chk("t3_ovf", 32'(bus.overflow), 1);
    chk("t3_level_kept", 32'(bus.level), 4);
    chk("t3_head", 32'(bus.out_data), 32'h01);
    bus.clear_ovf = 1'b1;
    tick();
    chk("t3_set_wins", 32'(bus.overflow), 1);
    bus.capture = 1'b0;
    tick();
    chk("t3_clear", 32'(bus.overflow), 0);
    bus.clear_ovf = 1'b0;
    // 4: full with simultaneous pop and push
    bus.capture = 1'b1;
    bus.out_ready = 1'b1;
    bus.count_in = 4'd6;
    tick();
    bus.capture = 1'b0;
    chk("t4_level", 32'(bus.level), 4);
    chk("t4_noovf", 32'(bus.overflow), 0);
    chk("t4_head", 32'(bus.out_data), 32'h02);
    tick();
    chk("t4_d3", 32'(bus.out_data), 32'h03);
    tick();
    chk("t4_d4", 32'(bus.out_data), 32'h04);
    tick();
    chk("t4_d6", 32'(bus.out_data), 32'h06);
    tick();
    chk("t4_empty", 32'(bus.out_valid), 0);
    // 5: capture held across 15->0
    bus.out_ready = 1'b0;
    bus.count_in = 4'd14;
    tick();
    bus.capture = 1'b1;
    bus.count_in = 4'd15;
    tick();
    bus.count_in = 4'd0;
    tick();
    bus.capture = 1'b0;
    chk("t5_level", 32'(bus.level), 2);
    chk("t5_wrap", 32'(bus.wrap_pulse), 1);
    chk("t5_e0", 32'(bus.out_data), 32'h0f);
    bus.out_ready = 1'b1;
    tick();
    chk("t5_e1", 32'(bus.out_data), 32'h10);
    tick();
    chk("t5_empty", 32'(bus.out_valid), 0);
    // 6: raise epoch to 5, queue entries with overflow, then reset mid-operation
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.count_in = 4'd15;
      tick();
      bus.count_in = 4'd0;
      tick();
    end
    bus.capture = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      bus.count_in = 4'(i);
      tick();
    end
    bus.capture = 1'b0;
    chk("t6_ovf", 32'(bus.overflow), 1);
    chk("t6_e5", 32'(bus.out_data), 32'h52);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("t6_level2", 32'(bus.level), 2);
    chk("t6_head", 32'(bus.out_data), 32'h54);
    do_reset();
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_level", 32'(bus.level), 0);
    chk("t6_rst_ovf", 32'(bus.overflow), 0);
    chk("t6_rst_wrap", 32'(bus.wrap_pulse), 0);
    bus.capture = 1'b1;
    bus.count_in = 4'd7;
    tick();
    bus.capture = 1'b0;
    chk("t6_epoch0", 32'(bus.out_data), 32'h07);
    bus.count_in = 4'd15;
    tick();
    bus.capture = 1'b1;
    bus.count_in = 4'd0;
    tick();
    bus.capture = 1'b0;
    chk("t6_level_after", 32'(bus.level), 2);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_epoch1", 32'(bus.out_data), 32'h10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
